// File: rtl/coin_pulse_pkg.sv
// Shared types and helpers for the coin pulse generator.
// Optional per-channel coin queue is enabled by defining COIN_PULSE_QUEUE_EN.
package coin_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_e;

  localparam int unsigned QUEUE_W = 4;

  // Frame counter must hold values up to max(PULSE_FRAMES, GAP_FRAMES).
  function automatic int unsigned cnt_width(input int unsigned pulse_frames,
                                            input int unsigned gap_frames);
    int unsigned max_frames;
    max_frames = (pulse_frames > gap_frames) ? pulse_frames : gap_frames;
    if (max_frames < 32'd1) begin
      return 32'd1;
    end else begin
      return $clog2(max_frames + 32'd1);
    end
  endfunction

  localparam int unsigned DEF_CNT_W = cnt_width(32'd4, 32'd12);

endpackage

// File: rtl/coin_pulse_chan.sv
// One coin channel: release detect, IDLE/PULSE/GAP sequencer, frame counter
// and (with COIN_PULSE_QUEUE_EN) a saturating pending-coin queue.
module coin_pulse_chan
  import coin_pulse_pkg::*;
#(
  parameter int unsigned PULSE_FRAMES = 4,
  parameter int unsigned GAP_FRAMES   = 12,
  parameter int unsigned QUEUE_DEPTH  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               button,
  output logic               pulse,
  output logic               busy,
  output logic [QUEUE_W-1:0] pending
);

  localparam int unsigned CNT_W = cnt_width(PULSE_FRAMES, GAP_FRAMES);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prev_button_q, prev_button_d;
  logic               pulse_q, pulse_d;
  logic               busy_q, busy_d;
  logic               ev_s;
  logic               gap_done_s;
  logic               gap_restart_s;
  logic               queue_nz_d;
  logic [CNT_W-1:0]   cnt_inc_s;

  always_comb begin
    prev_button_d = button;
    ev_s          = prev_button_q & ~button;
    cnt_inc_s     = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    if (GAP_FRAMES == 0) begin
      gap_done_s = 1'b1;
    end else begin
      gap_done_s = tick & (cnt_inc_s == CNT_W'(GAP_FRAMES));
    end
  end

`ifdef COIN_PULSE_QUEUE_EN
  logic [QUEUE_W-1:0] queue_q, queue_d, queue_add_s;

  // An event arriving in PULSE/GAP is folded in before the GAP exit decision.
  always_comb begin
    queue_d = queue_q;
    if (ev_s && (queue_q < QUEUE_W'(QUEUE_DEPTH))) begin
      queue_add_s = queue_q + 4'd1;
    end else begin
      queue_add_s = queue_q;
    end
    gap_restart_s = (queue_add_s != 4'd0);
    case (state_q)
      PULSE: queue_d = queue_add_s;
      GAP: begin
        if (gap_done_s && gap_restart_s) begin
          queue_d = queue_add_s - 4'd1;
        end else begin
          queue_d = queue_add_s;
        end
      end
      default: queue_d = queue_q;
    endcase
    queue_nz_d = (queue_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      queue_q <= 4'd0;
    end else begin
      queue_q <= queue_d;
    end
  end

  assign pending = queue_q;
`else
  // Without a queue only a release coinciding with the GAP exit restarts PULSE.
  always_comb begin
    gap_restart_s = ev_s;
    queue_nz_d    = 1'b0;
  end

  assign pending = 4'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (ev_s) begin
          state_d = PULSE;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      PULSE: begin
        if (tick) begin
          if (cnt_inc_s == CNT_W'(PULSE_FRAMES)) begin
            state_d = GAP;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            cnt_d = cnt_inc_s;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      GAP: begin
        if (gap_done_s) begin
          cnt_d   = {CNT_W{1'b0}};
          state_d = gap_restart_s ? PULSE : IDLE;
        end else if (tick) begin
          cnt_d = cnt_inc_s;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    pulse_d = (state_d == PULSE);
    busy_d  = (state_d != IDLE) | queue_nz_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= {CNT_W{1'b0}};
      prev_button_q <= 1'b0;
      pulse_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      prev_button_q <= prev_button_d;
      pulse_q       <= pulse_d;
      busy_q        <= busy_d;
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

endmodule

// File: rtl/coin_pulse_gen.sv
// Coin pulse generator top: shared vblank frame tick plus CHANNELS channels.
// Define COIN_PULSE_QUEUE_EN to queue coins inserted while a channel is busy.
module coin_pulse_gen
  import coin_pulse_pkg::*;
#(
  parameter int unsigned CHANNELS     = 2,
  parameter int unsigned PULSE_FRAMES = 4,
  parameter int unsigned GAP_FRAMES   = 12,
  parameter int unsigned QUEUE_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  vblank,
  input  logic [CHANNELS-1:0]   button,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   busy,
  output logic [4*CHANNELS-1:0] pending
);

  logic prev_vblank_q, prev_vblank_d;
  logic tick_s;

  // Reset loads 1 so a high vblank right after reset is not a tick.
  always_comb begin
    prev_vblank_d = vblank;
    tick_s        = vblank & ~prev_vblank_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_vblank_q <= 1'b1;
    end else begin
      prev_vblank_q <= prev_vblank_d;
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    coin_pulse_chan #(
      .PULSE_FRAMES (PULSE_FRAMES),
      .GAP_FRAMES   (GAP_FRAMES),
      .QUEUE_DEPTH  (QUEUE_DEPTH)
    ) u_chan (
      .clk     (clk),
      .reset   (reset),
      .tick    (tick_s),
      .button  (button[i]),
      .pulse   (pulse[i]),
      .busy    (busy[i]),
      .pending (pending[4*i +: 4])
    );
  end

endmodule

// File: tb/tb_coin_pulse_gen.sv
// Directed self-checking bench for coin_pulse_gen; follows COIN_PULSE_QUEUE_EN.
module tb_coin_pulse_gen;

  logic       clk = 1'b0;
  logic       reset;
  logic       vblank_a, vblank_b;
  logic [1:0] button_a, button_b;
  logic [1:0] pulse_a, busy_a, pulse_b, busy_b;
  logic [7:0] pending_a, pending_b;
  int         checks = 0;
  int         failures = 0;
  int         rises, low_cnt, hi_cnt;
  logic       prev_p;

  always #5 clk = ~clk;

  coin_pulse_gen dut_a (
    .clk(clk), .reset(reset), .vblank(vblank_a), .button(button_a),
    .pulse(pulse_a), .busy(busy_a), .pending(pending_a)
  );

  coin_pulse_gen #(.CHANNELS(2), .PULSE_FRAMES(1), .GAP_FRAMES(0), .QUEUE_DEPTH(3)) dut_b (
    .clk(clk), .reset(reset), .vblank(vblank_b), .button(button_b),
    .pulse(pulse_b), .busy(busy_b), .pending(pending_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic tick_a();
    vblank_a = 1'b1;
    step();
    vblank_a = 1'b0;
    step();
  endtask

  task automatic release_a(input int ch);
    button_a[ch] = 1'b1;
    step();
    button_a[ch] = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; vblank_a = 1'b0; vblank_b = 1'b0; button_a = 2'b00; button_b = 2'b00;
    repeat (3) step();
    chk("reset_pulse", 32'(pulse_a), 32'd0);
    chk("reset_busy", 32'(busy_a), 32'd0);
    chk("reset_pending", 32'(pending_a), 32'd0);
    reset = 1'b0;
    step();

    // Release in the reset cycle is ignored
    button_a = 2'b11; step();
    reset = 1'b1; button_a = 2'b00; step();
    reset = 1'b0; step(); step();
    chk("rst_evt_ignored", 32'(busy_a), 32'd0);

    // Single coin: 4 frames high, 12 frames gap
    release_a(0);
    chk("single_rise", 32'(pulse_a), 32'h1);
    chk("single_busy", 32'(busy_a), 32'h1);
    repeat (3) tick_a();
    chk("single_hold3", 32'(pulse_a), 32'h1);
    tick_a();
    chk("single_fall4", 32'(pulse_a), 32'h0);
    chk("single_gap_busy", 32'(busy_a), 32'h1);
    repeat (11) tick_a();
    chk("single_gap11", 32'(busy_a), 32'h1);
    tick_a();
    chk("single_idle", 32'(busy_a), 32'h0);

    // Release on the final GAP tick restarts PULSE directly
    release_a(0);
    repeat (15) tick_a();
    chk("gapexit_pre", 32'(busy_a), 32'h1);
    button_a[0] = 1'b1; step();
    vblank_a = 1'b1; button_a[0] = 1'b0; step();
    chk("gapexit_restart", 32'(pulse_a), 32'h1);
    chk("gapexit_pending", 32'(pending_a), 32'h0);
    vblank_a = 1'b0; step();
    repeat (16) tick_a();
    chk("gapexit_idle", 32'(busy_a), 32'h0);

    // Burst of releases on ch1 while pulsing
    release_a(1);
`ifdef COIN_PULSE_QUEUE_EN
    repeat (4) release_a(1);
    chk("burst_pending", 32'(pending_a[7:4]), 32'd3);
`else
    repeat (3) release_a(1);
    chk("burst_pending", 32'(pending_a), 32'd0);
`endif
    chk("burst_pulse", 32'(pulse_a), 32'h2);
    rises = 0; low_cnt = 0; prev_p = 1'b1;
    for (int i = 0; i < 70; i++) begin
      tick_a();
      if (pulse_a[1] && !prev_p) begin
        rises++;
        chk("burst_gap_len", 32'(low_cnt), 32'd12);
      end
      if (pulse_a[1]) low_cnt = 0; else low_cnt++;
      prev_p = pulse_a[1];
    end
`ifdef COIN_PULSE_QUEUE_EN
    chk("burst_extra_pulses", 32'(rises), 32'd3);
`else
    chk("burst_extra_pulses", 32'(rises), 32'd0);
`endif
    chk("burst_idle", 32'(busy_a), 32'h0);
    chk("burst_pending_end", 32'(pending_a), 32'h0);

    // Reset two frames into a pulse aborts it without replay
    release_a(0);
`ifdef COIN_PULSE_QUEUE_EN
    repeat (2) release_a(0);
    chk("abort_pending", 32'(pending_a[3:0]), 32'd2);
`endif
    repeat (2) tick_a();
    chk("abort_pre", 32'(pulse_a), 32'h1);
    reset = 1'b1; step();
    chk("abort_pulse", 32'(pulse_a), 32'h0);
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_pending0", 32'(pending_a), 32'h0);
    reset = 1'b0; step();
    hi_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick_a();
      if (pulse_a != 2'b00) hi_cnt++;
    end
    chk("abort_no_replay", 32'(hi_cnt), 32'd0);

    // Simultaneous releases on both channels
    button_a = 2'b11; step();
    button_a = 2'b00; step();
    chk("both_rise", 32'(pulse_a), 32'h3);
    repeat (16) tick_a();
    chk("both_idle", 32'(busy_a), 32'h0);

    // PULSE_FRAMES=1, GAP_FRAMES=0 variant
    button_b = 2'b11; step();
    button_b = 2'b00; step();
    chk("fast_rise", 32'(pulse_b), 32'h3);
`ifdef COIN_PULSE_QUEUE_EN
    button_b = 2'b11; step();
    button_b = 2'b00; step();
    chk("fast_pending", 32'(pending_b), 32'h11);
`endif
    vblank_b = 1'b1; step();
    chk("fast_gap", 32'(pulse_b), 32'h0);
    chk("fast_gap_busy", 32'(busy_b), 32'h3);
    vblank_b = 1'b0; step();
`ifdef COIN_PULSE_QUEUE_EN
    chk("fast_requeue", 32'(pulse_b), 32'h3);
    chk("fast_pending0", 32'(pending_b), 32'h0);
    vblank_b = 1'b1; step();
    chk("fast_gap2", 32'(pulse_b), 32'h0);
    vblank_b = 1'b0; step();
`endif
    chk("fast_idle", 32'(busy_b), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
